// File: rtl/weight_loader_if.sv
// Byte-stream and weight-bank bundle for weight_loader: host handshake in, bank write port out.
interface weight_loader_if #(
  parameter int DW = 8,
  parameter int AW = 5
) ();
  logic [DW-1:0] iData;
  logic          iValid;
  logic          oReady;
  logic          oWren;
  logic [AW-1:0] oAddr;
  logic [DW-1:0] oWeight;

  modport master (
    output iData, iValid,
    input  oReady, oWren, oAddr, oWeight
  );

  modport slave (
    input  iData, iValid,
    output oReady, oWren, oAddr, oWeight
  );
endinterface

// File: rtl/weight_loader.sv
// Write-side sequencer for the 5x5 kernel weight bank: numbers incoming bytes 0..NUM_W-1 and strobes them in.
// Optional trailing checksum byte is enabled with the WLD_CHECKSUM_EN macro.
module weight_loader #(
  parameter int NUM_W   = 25,
  parameter int DW      = 8,
  parameter int AW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic           iCLK,
  input  logic           iRSTn,
  input  logic           iStart,
  weight_loader_if.slave bus,
  output logic           oBusy,
  output logic           oDone,
  output logic           oErr
);

  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

`ifdef WLD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHK = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t        state;
  logic [AW-1:0] count;
  logic [TW-1:0] idleCnt;
  logic          xfer;
  logic          timeoutHit;
  logic          lastByte;

`ifdef WLD_CHECKSUM_EN
  logic [7:0] sum;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [DW-1:0] w);
    return acc + 8'(w);
  endfunction
`endif

  // oReady is registered, so a transfer is decided entirely by this cycle's flops and iValid.
  assign xfer       = bus.iValid & bus.oReady;
  assign lastByte   = (count == AW'(NUM_W - 1));
  assign timeoutHit = (TIMEOUT > 0) && (idleCnt == TW'(TLIM));

  // Load sequencer: state, counters and every registered output.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state       <= IDLE;
      count       <= {AW{1'b0}};
      idleCnt     <= {TW{1'b0}};
      bus.oReady  <= 1'b0;
      bus.oWren   <= 1'b0;
      bus.oAddr   <= {AW{1'b0}};
      bus.oWeight <= {DW{1'b0}};
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oErr        <= 1'b0;
`ifdef WLD_CHECKSUM_EN
      sum         <= 8'd0;
`endif
    end else begin
      bus.oWren <= 1'b0;
      oDone     <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            state      <= LOAD;
            count      <= {AW{1'b0}};
            idleCnt    <= {TW{1'b0}};
            bus.oReady <= 1'b1;
            oBusy      <= 1'b1;
            oErr       <= 1'b0;
`ifdef WLD_CHECKSUM_EN
            sum        <= 8'd0;
`endif
          end else begin
            bus.oReady <= 1'b0;
            oBusy      <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            bus.oWren   <= 1'b1;
            bus.oAddr   <= count;
            bus.oWeight <= bus.iData;
            idleCnt     <= {TW{1'b0}};
`ifdef WLD_CHECKSUM_EN
            sum         <= sum8(sum, bus.iData);
`endif
            if (lastByte) begin
              count <= {AW{1'b0}};
`ifdef WLD_CHECKSUM_EN
              state <= CHK;
`else
              state      <= DONE;
              bus.oReady <= 1'b0;
              oDone      <= 1'b1;
`endif
            end else begin
              count <= count + AW'(1);
            end
          end else if (timeoutHit) begin
            state      <= IDLE;
            count      <= {AW{1'b0}};
            idleCnt    <= {TW{1'b0}};
            bus.oReady <= 1'b0;
            oBusy      <= 1'b0;
            oErr       <= 1'b1;
          end else begin
            idleCnt <= idleCnt + TW'(1);
          end
        end
`ifdef WLD_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            state      <= DONE;
            idleCnt    <= {TW{1'b0}};
            bus.oReady <= 1'b0;
            oDone      <= 1'b1;
            if (8'(bus.iData) != sum) begin
              oErr <= 1'b1;
            end else begin
              oErr <= oErr;
            end
          end else if (timeoutHit) begin
            state      <= IDLE;
            count      <= {AW{1'b0}};
            idleCnt    <= {TW{1'b0}};
            bus.oReady <= 1'b0;
            oBusy      <= 1'b0;
            oErr       <= 1'b1;
          end else begin
            idleCnt <= idleCnt + TW'(1);
          end
        end
`endif
        DONE: begin
          state      <= IDLE;
          bus.oReady <= 1'b0;
          oBusy      <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          count      <= {AW{1'b0}};
          idleCnt    <= {TW{1'b0}};
          bus.oReady <= 1'b0;
          oBusy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader (TIMEOUT=8); checksum scenarios build with WLD_CHECKSUM_EN.
module tb_weight_loader;
  localparam int NUM_W = 25;
  localparam int DW    = 8;
  localparam int AW    = 5;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic iCLK = 1'b0;
  logic iRSTn;
  logic iStart;
  logic oBusy, oDone, oErr;

  int checks = 0;
  int errors = 0;
  int wrSeen = 0;
  logic [7:0] sumModel;

  wr_t  expWr[$];
  logic expDone[$];

  weight_loader_if #(.DW(DW), .AW(AW)) bus ();

  weight_loader #(.NUM_W(NUM_W), .DW(DW), .AW(AW), .TIMEOUT(8)) dut (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iStart(iStart),
    .bus   (bus),
    .oBusy (oBusy),
    .oDone (oDone),
    .oErr  (oErr)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard queues.
  always @(negedge iCLK) begin
    if (iRSTn) begin
      if (bus.oWren) begin
        wr_t e;
        wrSeen++;
        if (expWr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0d data=%0h required none", bus.oAddr, bus.oWeight);
        end else begin
          e = expWr.pop_front();
          check("wr_addr", int'(bus.oAddr), int'(e.a));
          check("wr_data", int'(bus.oWeight), int'(e.d));
        end
      end
      if (oDone) begin
        if (expDone.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
        end else begin
          check("done_err", int'(oErr), int'(expDone.pop_front()));
          check("done_busy", int'(oBusy), 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic doStart();
    iStart   = 1'b1;
    sumModel = 8'h00;
    tick();
    iStart = 1'b0;
  endtask

  task automatic sendBytes(input int n, input logic [7:0] base, input logic [7:0] inc,
                           input bit thr, input int pokeAt);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d          = base + 8'(i) * inc;
      bus.iData  = d;
      bus.iValid = 1'b1;
      iStart     = (i == pokeAt);
      sumModel   = sumModel + d;
      expWr.push_back('{a: AW'(i), d: d});
`ifndef WLD_CHECKSUM_EN
      if (i == NUM_W - 1) expDone.push_back(1'b0);
`endif
      tick();
      iStart = 1'b0;
      if (thr && i != n - 1) begin
        bus.iValid = 1'b0;
        tick();
      end
    end
  endtask

  // Ends a full load; in the checksum build the trailing byte is the sum, or sum+1 when bad.
  task automatic completeLoad(input bit bad);
`ifdef WLD_CHECKSUM_EN
    bus.iData  = bad ? sumModel + 8'h01 : sumModel;
    bus.iValid = 1'b1;
    expDone.push_back(bad);
    tick();
`endif
    bus.iData  = 8'hFF;
    bus.iValid = 1'b1;
    check("done_pulse", int'(oDone), 1);
    check("done_ready", int'(bus.oReady), 0);
    check("done_errflag", int'(oErr), int'(bad));
    tick();
    bus.iValid = 1'b0;
    check("after_busy", int'(oBusy), 0);
    check("after_done", int'(oDone), 0);
    check("after_queue", expWr.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_ready"}, int'(bus.oReady), 0);
    check({tag, "_wren"}, int'(bus.oWren), 0);
    check({tag, "_addr"}, int'(bus.oAddr), 0);
    check({tag, "_weight"}, int'(bus.oWeight), 0);
    check({tag, "_busy"}, int'(oBusy), 0);
    check({tag, "_done"}, int'(oDone), 0);
    check({tag, "_err"}, int'(oErr), 0);
  endtask

  initial begin
    int w0;
    iRSTn      = 1'b0;
    iStart     = 1'b0;
    bus.iData  = 8'h00;
    bus.iValid = 1'b0;
    sumModel   = 8'h00;
    #12;
    checkAllZero("reset");
    @(posedge iCLK);
    #1;
    iRSTn = 1'b1;
    tick();

    // Start together with a valid byte: the byte must not be taken in IDLE.
    bus.iValid = 1'b1;
    bus.iData  = 8'hEE;
    doStart();
    bus.iValid = 1'b0;
    check("start_busy", int'(oBusy), 1);
    check("start_ready", int'(bus.oReady), 1);
    w0 = wrSeen;
    sendBytes(NUM_W, 8'h01, 8'h01, 1'b0, -1);
    completeLoad(1'b0);
    check("basic_writes", wrSeen - w0, NUM_W);

    doStart();
    w0 = wrSeen;
    sendBytes(NUM_W, 8'hA0, 8'h01, 1'b1, -1);
    completeLoad(1'b0);
    check("throttle_writes", wrSeen - w0, NUM_W);

    // Ten bytes then silence: abort on the eighth idle cycle.
    doStart();
    sendBytes(10, 8'h30, 8'h01, 1'b0, -1);
    bus.iValid = 1'b0;
    repeat (7) tick();
    check("to_still_busy", int'(oBusy), 1);
    tick();
    check("to_busy", int'(oBusy), 0);
    check("to_err", int'(oErr), 1);
    check("to_ready", int'(bus.oReady), 0);
    check("to_queue", expWr.size(), 0);
    repeat (3) tick();
    check("to_err_sticky", int'(oErr), 1);
    doStart();
    check("to_err_cleared", int'(oErr), 0);
    sendBytes(NUM_W, 8'h01, 8'h01, 1'b0, -1);
    completeLoad(1'b0);

    // iStart during LOAD at count 5 must not restart the address sequence.
    doStart();
    w0 = wrSeen;
    sendBytes(NUM_W, 8'h50, 8'h01, 1'b0, 5);
    completeLoad(1'b0);
    check("ignstart_writes", wrSeen - w0, NUM_W);

    // Reset after twelve transfers, once the twelfth write has been seen.
    doStart();
    sendBytes(12, 8'h70, 8'h01, 1'b0, -1);
    bus.iValid = 1'b0;
    @(negedge iCLK);
    #1;
    iRSTn = 1'b0;
    #1;
    checkAllZero("midrst");
    check("midrst_queue", expWr.size(), 0);
    repeat (2) tick();
    iRSTn = 1'b1;
    tick();
    doStart();
    sendBytes(NUM_W, 8'h01, 8'h01, 1'b0, -1);
    completeLoad(1'b0);

`ifdef WLD_CHECKSUM_EN
    doStart();
    w0 = wrSeen;
    sendBytes(NUM_W, 8'h10, 8'h00, 1'b0, -1);
    check("cks_model", int'(sumModel), 8'h90);
    completeLoad(1'b0);
    check("cks_good_writes", wrSeen - w0, NUM_W);

    doStart();
    w0 = wrSeen;
    sendBytes(NUM_W, 8'h10, 8'h00, 1'b0, -1);
    completeLoad(1'b1);
    check("cks_bad_writes", wrSeen - w0, NUM_W);
`endif

    repeat (4) tick();
    check("final_wr_queue", expWr.size(), 0);
    check("final_done_queue", expDone.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Write-side sequencer for the 25-entry 5x5 kernel weight register bank.
- Accepts a byte stream from the host side (UART/bus bridge) over a valid/ready handshake.
- Assigns consecutive addresses 0..NUM_W-1 to the bytes and drives the bank's write strobe, address and data.
- Reports busy, done and error status to the control FSM.

Parameters:
- NUM_W, 25, number of weights per load; address range 0..NUM_W-1.
- DW, 8, weight width in bits.
- AW, 5, address width; must satisfy 2^AW >= NUM_W.
- TIMEOUT, 255, maximum idle cycles between accepted bytes while loading before the load aborts; 0 disables the timeout.

Ports:
- iCLK  in  1  clock; all logic on the rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iStart  in  1  single-cycle request to begin a load; ignored unless the state is IDLE.
- iData  in  DW  incoming weight byte.
- iValid  in  1  iData is valid.
- oReady  out  1  loader accepts iData this cycle.
- oWren  out  1  write strobe to the weight bank.
- oAddr  out  AW  weight index to write.
- oWeight  out  DW  weight value to write.
- oBusy  out  1  load in progress.
- oDone  out  1  one-cycle pulse on successful completion.
- oErr  out  1  sticky error flag; cleared by the next accepted iStart.

Behaviour:
- Reset (async, iRSTn=0):
  - state=IDLE, byte count=0, idle counter=0.
  - All outputs 0: oReady, oWren, oAddr, oWeight, oBusy, oDone, oErr.
- All outputs are registered.
- IDLE:
  - oReady=0, oBusy=0.
  - iStart=1 -> LOAD; count=0; idle counter=0; oErr cleared to 0 on the same edge.
- LOAD:
  - oReady=1, oBusy=1.
  - Transfer occurs when iValid && oReady.
  - On a transfer, the next cycle has oWren=1, oAddr=count, oWeight=iData. Latency is 1 cycle.
  - count increments on each transfer.
  - In any cycle without a transfer, oWren=0.
  - oAddr and oWeight hold their last values when oWren=0.
- Completion:
  - The transfer with count==NUM_W-1 is the last data byte.
  - Without the feature, the next state is DONE.
  - oReady deasserts in the cycle after the last transfer, so back-to-back valid bytes are never over-accepted.
- DONE:
  - Lasts exactly one cycle: oDone=1, oBusy=1, oReady=0.
  - The last oWren pulse coincides with the DONE cycle.
  - Next state is IDLE.
- Timeout:
  - Applies in LOAD (and CHK) when TIMEOUT>0.
  - The idle counter increments on every cycle without a transfer and resets to 0 on each transfer.
  - When the counter reaches TIMEOUT: next state IDLE, oErr=1, no oDone.
  - Weights already written stay written (partial load); count resets to 0.
- iStart while not in IDLE: ignored; it neither restarts nor clears oErr.
- iStart with iValid in the same IDLE cycle: the byte is not accepted, because oReady=0 in IDLE.
- Count width is AW bits. The count never exceeds NUM_W-1, so no wrap-around is possible.
- Reset mid-load: immediate return to the reset state; no further oWren.

Optional Feature:
- Macro: WLD_CHECKSUM_EN.
- Defined:
  - After the last data transfer, the state goes to CHK instead of DONE. CHK has oReady=1 and oBusy=1.
  - A running 8-bit sum (mod 256) of all NUM_W weights is accumulated during LOAD and cleared on iStart.
  - The byte accepted in CHK is compared with that sum. It is not written (oWren=0).
  - Match -> DONE, oDone pulses.
  - Mismatch -> DONE, oDone pulses and oErr=1.
  - The timeout also applies in CHK.
- Undefined: no CHK state and no sum register; oErr is set only by timeout.

Test Plan:
- Basic load: reset, iStart, then 25 back-to-back valid bytes 0x01..0x19 -> oWren pulses with oAddr 0..24 and oWeight 0x01..0x19, each 1 cycle after its transfer; oDone=1 for one cycle; oBusy falls the following cycle.
- Throttled source: iValid toggled 1/0 each cycle with bytes 0xA0..0xB8 -> exactly 25 writes, no gaps mis-addressed, no duplicate addresses.
- Timeout (TIMEOUT=8): 10 bytes then iValid=0 for 8 cycles -> return to IDLE, oErr=1, no oDone, last write at oAddr=9; the next iStart clears oErr.
- Mid-load reset: assert iRSTn=0 after 12 transfers -> all outputs 0 immediately; new iStart begins again at oAddr=0.
- Ignored start: pulse iStart during LOAD at count=5 -> no restart; addresses continue 5..24.
- With WLD_CHECKSUM_EN:
  - 25 bytes of 0x10 followed by check byte 0x90 (25*16=400, mod 256) -> oDone=1, oErr=0.
  - Same load with check byte 0x91 -> oDone=1, oErr=1; exactly 25 writes in both cases.
